// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaled tick, parallel load and a
// registered active-low seven-segment decode with optional leading-zero blanking.
module bcd_counter_display #(
  parameter int DIGITS        = 4,
  parameter int DIV           = 50000000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  function automatic logic [6:0] segOf(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Walk from the most significant digit down; a digit stays blank while
  // every digit above it (and itself) is still zero.
  function automatic logic [7*DIGITS-1:0] displayOf(input logic [4*DIGITS-1:0] v);
    logic [7*DIGITS-1:0] result;
    logic                leading;
    result  = '1;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'd0) leading = 1'b0;
      if (BLANK_LEADING && leading && (i > 0))
        result[7*i +: 7] = 7'b1111111;
      else
        result[7*i +: 7] = segOf(v[4*i +: 4]);
    end
    return result;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RESET = displayOf('0);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                wrap_q, wrap_d;
  logic                tick;
  logic                carry;
  logic [3:0]          nib;

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    nib     = 4'd0;
    tick    = en && (presc_q == PRESC_MAX);
    hex_d   = displayOf(bcd_q);

    if (load) begin
      presc_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
        nib = load_val[4*i +: 4];
        bcd_d[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
      end
    end else begin
      if (en) presc_d = tick ? '0 : presc_q + PW'(1);
      // Ripple carry/borrow; a carry out of the top digit is the wrap.
      if (tick) begin
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
          nib = bcd_q[4*i +: 4];
          if (carry) begin
            if (up) begin
              if (nib == 4'd9) nib = 4'd0;
              else begin
                nib   = nib + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (nib == 4'd0) nib = 4'd9;
              else begin
                nib   = nib - 4'd1;
                carry = 1'b0;
              end
            end
          end
          bcd_d[4*i +: 4] = nib;
        end
        wrap_d = carry;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_q <= '0;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= HEX_RESET;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
    end
  end

  assign bcd  = bcd_q;
  assign hex  = hex_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench: two counters (DIV=3 blanked, DIV=5 unblanked) share stimulus
// and are checked against an integer-arithmetic model of the counter.
module tb_bcd_counter_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [15:0] loadVal = '0;
  logic [15:0] bcdA, bcdB;
  logic [27:0] hexA, hexB;
  logic        wrapA, wrapB;

  always #5 clk = ~clk;

  bcd_counter_display #(.DIGITS(4), .DIV(3), .BLANK_LEADING(1'b1)) dutA (
    .CLOCK_50(clk), .RESET(reset), .en(en), .up(up), .load(load),
    .load_val(loadVal), .bcd(bcdA), .hex(hexA), .wrap(wrapA)
  );

  bcd_counter_display #(.DIGITS(4), .DIV(5), .BLANK_LEADING(1'b0)) dutB (
    .CLOCK_50(clk), .RESET(reset), .en(en), .up(up), .load(load),
    .load_val(loadVal), .bcd(bcdB), .hex(hexB), .wrap(wrapB)
  );

  typedef struct {
    logic [1:0][15:0] bcd;
    logic [1:0]       wrap;
    logic [1:0][27:0] hex;
    int               cyc;
  } want_t;

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam int DIVS [2] = '{3, 5};
  localparam bit BLANKS [2] = '{1'b1, 1'b0};

  want_t expQ [$];
  int    mCount [2];
  int    mPresc [2];
  int    cycleNo = 0;
  int    vectorCount = 0;
  int    missCount = 0;

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] toHex(input int v, input bit blank);
    logic [27:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (blank && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int fromLoad(input logic [15:0] lv);
    int sum, p, d;
    sum = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      sum = sum + d * p;
      p = p * 10;
    end
    return sum;
  endfunction

  // Drive one cycle of inputs and queue what both counters must show after the edge.
  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit ld,
                               input logic [15:0] lv);
    want_t w;
    int hexSrc;
    bit tick;
    @(negedge clk);
    #1;
    reset = r; en = e; up = u; load = ld; loadVal = lv;
    for (int k = 0; k < 2; k++) begin
      w.wrap[k] = 1'b0;
      hexSrc = r ? 0 : mCount[k];
      if (r) begin
        mCount[k] = 0;
        mPresc[k] = 0;
      end else if (ld) begin
        mCount[k] = fromLoad(lv);
        mPresc[k] = 0;
      end else if (e) begin
        tick = (mPresc[k] == DIVS[k] - 1);
        mPresc[k] = tick ? 0 : mPresc[k] + 1;
        if (tick && u) begin
          w.wrap[k] = (mCount[k] == 9999);
          mCount[k] = (mCount[k] + 1) % 10000;
        end else if (tick) begin
          w.wrap[k] = (mCount[k] == 0);
          mCount[k] = (mCount[k] + 9999) % 10000;
        end
      end
      w.bcd[k] = toBcd(mCount[k]);
      w.hex[k] = toHex(hexSrc, BLANKS[k]);
    end
    w.cyc = cycleNo;
    cycleNo++;
    expQ.push_back(w);
  endtask

  task automatic checkOutput(input string name, input int cyc,
                             input logic [27:0] actual, input logic [27:0] required);
    vectorCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, actual, required);
    end
  endtask

  // Monitor: every cycle is an output beat, compared half a clock after the edge.
  always @(negedge clk) begin
    want_t w;
    if (expQ.size() > 0) begin
      w = expQ.pop_front();
      checkOutput("bcdA", w.cyc, 28'(bcdA), 28'(w.bcd[0]));
      checkOutput("wrapA", w.cyc, 28'(wrapA), 28'(w.wrap[0]));
      checkOutput("hexA", w.cyc, hexA, w.hex[0]);
      checkOutput("bcdB", w.cyc, 28'(bcdB), 28'(w.bcd[1]));
      checkOutput("wrapB", w.cyc, 28'(wrapB), 28'(w.wrap[1]));
      checkOutput("hexB", w.cyc, hexB, w.hex[1]);
    end
  end

  initial begin
    logic [15:0] lv;
    bit r, e, ld;
    int pick;

    repeat (2) applyStimulus(1, 0, 0, 0, 16'h0000);
    repeat (40) applyStimulus(0, 1, 1, 0, 16'h0000);

    applyStimulus(0, 1, 1, 1, 16'h9999);
    repeat (6) applyStimulus(0, 1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 0, 1, 16'h0000);
    repeat (6) applyStimulus(0, 1, 0, 0, 16'h0000);

    applyStimulus(0, 0, 1, 1, 16'h0A35);
    repeat (2) applyStimulus(0, 0, 1, 0, 16'h0000);

    // Third cycle after the load lands on a DIV=3 tick, so that load wins.
    applyStimulus(0, 1, 1, 1, 16'h0128);
    repeat (2) applyStimulus(0, 1, 1, 0, 16'h0000);
    applyStimulus(0, 1, 1, 1, 16'h0500);
    repeat (2) applyStimulus(0, 1, 1, 0, 16'h0000);

    foreach (DIVS[i]) begin
      applyStimulus(0, 1, 1, 0, 16'h0000);
      applyStimulus(0, 1, 1, 0, 16'h0000);
      repeat (3) applyStimulus(0, 0, 1, 0, 16'h0000);
      repeat (4) applyStimulus(0, 1, 1, 0, 16'h0000);
    end

    repeat (2) applyStimulus(0, 1, 1, 0, 16'h0000);
    applyStimulus(1, 1, 1, 1, 16'h4321);
    repeat (7) applyStimulus(0, 1, 1, 0, 16'h0000);

    applyStimulus(0, 0, 1, 1, 16'h0042);
    repeat (2) applyStimulus(0, 0, 1, 0, 16'h0000);

    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      e  = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 3);
      if (pick == 0) lv = 16'h9999;
      else if (pick == 1) lv = 16'h0000;
      else lv = 16'($urandom);
      applyStimulus(r, e, 1'($urandom), ld, lv);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("queueDrained", cycleNo, 28'(expQ.size()), 28'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
